// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared types for the RV32M multiply/divide sequencer     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_sign_fix : operand magnitude/sign extraction and result       |
// |                   negation for the multiply/divide sequencer         |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module muldiv_sign_fix
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  muldiv_op_t     op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           neg_a_o,
  output logic           neg_b_o,
  output logic [W-1:0]   abs_a_o,
  output logic [W-1:0]   abs_b_o,
  input  logic [2*W-1:0] res_i,
  input  logic           res_neg_i,
  output logic [2*W-1:0] res_o
);

  assign neg_a_o = op_a_signed(op_i) & a_i[W-1];
  assign neg_b_o = op_b_signed(op_i) & b_i[W-1];
  assign abs_a_o = neg_a_o ? (~a_i + W'(1)) : a_i;
  assign abs_b_o = neg_b_o ? (~b_i + W'(1)) : b_i;

  // Results are corrected at full product width so MULH* see a proper borrow.
  assign res_o   = res_neg_i ? (~res_i + (2*W)'(1)) : res_i;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq : iterative RV32M multiply/divide sequencer (EX stage)    |
// |              MULDIV_FAST_MUL_EN selects a single-cycle multiplier    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int BYPASS_TRIVIAL = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  input  muldiv_op_t        op_i,
  input  logic [DATA_W-1:0] oper1_i,
  input  logic [DATA_W-1:0] oper2_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int                 c_CNT_W = $clog2(MULDIV_ITERS);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MULDIV_ITERS - 1);

  muldiv_state_t       r_state, w_state_nxt;
  muldiv_op_t          r_op;
  logic [c_CNT_W-1:0]  r_count;
  logic [2*DATA_W-1:0] r_acc, w_acc_step;
  logic [DATA_W-1:0]   r_opb, r_result;
  logic                r_neg_a, r_neg_b, r_div_zero;

  logic                w_neg_a, w_neg_b, w_res_neg;
  logic [DATA_W-1:0]   w_abs_a, w_abs_b, w_idle_res, w_final, w_sub;
  logic [2*DATA_W-1:0] w_res_raw, w_res_fix;
  logic [DATA_W:0]     w_shift, w_sum;
  logic                w_ge, w_is_div, w_is_quot, w_div_zero, w_ovf, w_trivial;

  muldiv_sign_fix #(.W(DATA_W)) u_sign_fix (
    .op_i      (op_i),
    .a_i       (oper1_i),
    .b_i       (oper2_i),
    .neg_a_o   (w_neg_a),
    .neg_b_o   (w_neg_b),
    .abs_a_o   (w_abs_a),
    .abs_b_o   (w_abs_b),
    .res_i     (w_res_raw),
    .res_neg_i (w_res_neg),
    .res_o     (w_res_fix)
  );

  assign w_is_div   = op_is_div(op_i);
  assign w_is_quot  = op_i inside {OP_DIV, OP_DIVU};
  assign w_div_zero = (oper2_i == '0);
  assign w_ovf      = op_b_signed(op_i) && (oper1_i == {1'b1, {(DATA_W-1){1'b0}}}) && (oper2_i == '1);
  assign w_trivial  = (BYPASS_TRIVIAL != 0) && w_is_div && (w_div_zero || w_ovf);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] w_fast_prod;
  // Sign-extended operands; only the low 2*DATA_W product bits are kept.
  assign w_fast_prod = {{DATA_W{w_neg_a}}, oper1_i} * {{DATA_W{w_neg_b}}, oper2_i};
`endif

  always_comb begin
    w_idle_res = '0;
    if (w_is_div) begin
      if (w_div_zero) w_idle_res = w_is_quot ? '1 : oper1_i;
      else            w_idle_res = w_is_quot ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      w_idle_res = (op_i == OP_MUL) ? w_fast_prod[DATA_W-1:0] : w_fast_prod[2*DATA_W-1:DATA_W];
    end
`endif
  end

  // r_acc = {remainder, quotient} for divide, {partial sum, multiplier} for multiply.
  assign w_shift    = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opb});
  assign w_sub      = w_shift[DATA_W-1:0] - r_opb;
  assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opb & {DATA_W{r_acc[0]}}};
  assign w_acc_step = (r_state == ST_DIV)
                    ? {(w_ge ? w_sub : w_shift[DATA_W-1:0]), r_acc[DATA_W-2:0], w_ge}
                    : {w_sum, r_acc[DATA_W-1:1]};

  always_comb begin
    w_res_raw = w_acc_step;
    w_res_neg = r_neg_a ^ r_neg_b;
    case (r_op)
      OP_DIV, OP_DIVU: begin
        w_res_raw = {{DATA_W{1'b0}}, w_acc_step[DATA_W-1:0]};
        w_res_neg = (r_neg_a ^ r_neg_b) & ~r_div_zero;
      end
      OP_REM, OP_REMU: begin
        w_res_raw = {{DATA_W{1'b0}}, w_acc_step[2*DATA_W-1:DATA_W]};
        w_res_neg = r_neg_a;
      end
      default: ;
    endcase
  end

  assign w_final = (r_op inside {OP_MULH, OP_MULHSU, OP_MULHU})
                 ? w_res_fix[2*DATA_W-1:DATA_W] : w_res_fix[DATA_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            if (w_is_div) w_state_nxt = w_trivial ? ST_DONE : ST_DIV;
`ifdef MULDIV_FAST_MUL_EN
            else          w_state_nxt = ST_DONE;
`else
            else          w_state_nxt = ST_MUL;
`endif
          end
        end
        ST_MUL, ST_DIV: if (r_count == c_LAST) w_state_nxt = ST_DONE;
        ST_DONE:        if (!hold_i) w_state_nxt = ST_IDLE;
        default:        w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_op       <= OP_MUL;
      r_count    <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (!flush_i) begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_op       <= op_i;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_div_zero <= w_div_zero;
            r_acc      <= {{DATA_W{1'b0}}, w_abs_a};
            r_opb      <= w_abs_b;
            r_count    <= '0;
            if (w_state_nxt == ST_DONE) r_result <= w_idle_res;
          end
        end
        ST_MUL, ST_DIV: begin
          r_acc   <= w_acc_step;
          r_count <= r_count + c_CNT_W'(1);
          if (r_count == c_LAST) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign stall_req_o    = valid_i & (r_state != ST_DONE) & ~flush_i;
  assign busy_o         = (r_state != ST_IDLE);
  assign result_valid_o = (r_state == ST_DONE);
  assign result_o       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_seq : self-checking bench for muldiv_seq                   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_muldiv_seq;
  import riscv_pkg::*;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold_n;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rstn, valid, hold, flush;
  muldiv_op_t  op;
  logic [31:0] oper1, oper2, result;
  logic        stall, busy, rvalid;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  muldiv_seq u_dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .valid_i        (valid),
    .op_i           (op),
    .oper1_i        (oper1),
    .oper2_i        (oper2),
    .hold_i         (hold),
    .flush_i        (flush),
    .stall_req_o    (stall),
    .busy_o         (busy),
    .result_valid_o (rvalid),
    .result_o       (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int          sa, sb;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (o)
      OP_MUL:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0];  end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       r = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b};             r = p[63:32]; end
      OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : sa / sb;
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    r = (b == 0) ? a : ovf ? 32'd0 : sa % sb;
      OP_REMU:   r = (b == 0) ? a : a % b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (o inside {OP_DIV, OP_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!op_is_div(o)) return MUL_LAT;
    return ((b == 0) || ovf) ? 0 : DIV_LAT;
  endfunction

  // Issue one op, wait for its result, optionally hold it, then retire it.
  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int hold_n);
    exp_t        e, got;
    int          n, stalls;
    logic [31:0] held;
    @(negedge clk);
    valid = 1'b1; op = o; oper1 = a; oper2 = b;
    e.res = exp; e.lat = lat;
    sb_q.push_back(e);
    #1 checkb("stall_req_request_cycle", stall, 1'b1);
    stalls = 1;
    @(posedge clk); #1;
    oper1 = $urandom; oper2 = $urandom;
    n = 0;
    while (!rvalid && n < 100) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      n++;
    end
    got = sb_q.pop_front();
    check("latency", n, got.lat);
    check("stall_cycles", stalls, got.lat + 1);
    checkb("stall_low_in_done", stall, 1'b0);
    check("result", result, got.res);
    held = result;
    hold = (hold_n > 0);
    for (int i = 0; i < hold_n; i++) begin
      @(posedge clk); #1;
      checkb("hold_valid", rvalid, 1'b1);
      check("hold_result", result, held);
    end
    hold = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    checkb("retire_busy", busy, 1'b0);
    checkb("retire_valid", rvalid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    muldiv_op_t  ro;
    logic [31:0] ra, rb;

    rstn = 1'b0; valid = 1'b0; hold = 1'b0; flush = 1'b0;
    op = OP_MUL; oper1 = '0; oper2 = '0;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 5};
    vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT, 0};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT, 0};
    vecs[4]  = '{OP_MULH,   32'hFFFF_FFFF,  32'd7,         32'hFFFF_FFFF, MUL_LAT, 0};
    vecs[5]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT, 0};
    vecs[6]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT, 0};
    vecs[7]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT, 0};
    vecs[8]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT, 2};
    vecs[9]  = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 0,       0};
    vecs[10] = '{OP_REM,    32'd5,          32'd0,         32'd5,         0,       0};
    vecs[11] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0,       0};
    vecs[12] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0,       3};
    vecs[13] = '{OP_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 0,       0};
    vecs[14] = '{OP_REMU,   32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 0,       0};

    #12;
    checkb("reset_stall", stall, 1'b0);
    checkb("reset_busy", busy, 1'b0);
    checkb("reset_valid", rvalid, 1'b0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold_n);

    for (int i = 0; i < 8; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(ro, ra, rb, ref_model(ro, ra, rb), exp_lat(ro, ra, rb), 0);
    end

    // Flush a DIV ten iterations in, then issue a MUL straight away.
    @(negedge clk);
    valid = 1'b1; op = OP_DIV; oper1 = 32'd100; oper2 = 32'd7;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkb("flush_stall_low", stall, 1'b0);
    checkb("flush_busy_before_edge", busy, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    checkb("flush_busy", busy, 1'b0);
    checkb("flush_valid", rvalid, 1'b0);
    run_op(OP_MUL, 32'd12345, 32'd678, 32'h007F_B6F6, MUL_LAT, 0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    valid = 1'b1; op = OP_MULHU; oper1 = 32'hFFFF_FFFF; oper2 = 32'hFFFF_FFFF;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0; valid = 1'b0;
    #1;
    checkb("async_rst_busy", busy, 1'b0);
    checkb("async_rst_valid", rvalid, 1'b0);
    checkb("async_rst_stall", stall, 1'b0);
    check("async_rst_result", result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the ALU in the execute stage.
- Accepts one M-extension op from ID/EX and runs a radix-2 shift-add multiplier or a restoring divider over multiple cycles.
- Raises a stall request into the pipeline control until the result is ready.
- Presents the result for one consumption cycle, and abandons work on flush.

Parameters:
- DATA_W, 32: operand/result width; only 32 is supported.
- BYPASS_TRIVIAL, 1: when 1, divide-by-zero and signed overflow finish without iterating.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  ID/EX holds a valid M-extension op.
- op_i  in  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- oper1_i  in  32  rs1 value after forwarding.
- oper2_i  in  32  rs2 value after forwarding.
- hold_i  in  1  downstream stall; EX must not advance.
- flush_i  in  1  kill the in-flight op.
- stall_req_o  out  1  request a pipeline stall while the op is unfinished.
- busy_o  out  1  FSM is not IDLE.
- result_valid_o  out  1  result_o holds the final value.
- result_o  out  32  rd value.

Behaviour:
- Reset (async, rstn_i low): state IDLE, count 0, all datapath registers 0. Outputs: stall_req_o 0, busy_o 0, result_valid_o 0, result_o 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If valid_i & !flush_i at an edge: latch op; compute absolute values and sign flags per op signedness; count <= 0.
  - MUL* go to MUL, DIV*/REM* go to DIV.
  - Trivial divide with BYPASS_TRIVIAL=1 goes straight to DONE with the special result.
- MUL: one partial-product add-shift per edge into a 64-bit accumulator. After 32 iterations (count==31), go to DONE, applying sign correction.
  - MUL takes the low 32 bits; MULH, MULHSU and MULHU take the high 32 bits.
- DIV: one restoring step per edge (shift remainder, trial subtract, set quotient bit). After 32 iterations, go to DONE.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Latency: request sampled at edge k; result_valid_o is high from the cycle after edge k+32. Trivial divide: from the cycle after edge k.
- DONE: result_valid_o=1, result_o stable.
  - If hold_i=1: stay in DONE.
  - Else: IDLE at the next edge, and the instruction leaves EX in that same cycle.
  - A new valid_i is never accepted directly from DONE.
- stall_req_o = valid_i & (state != DONE) & !flush_i, which is combinational. It is high in the request cycle itself, and low in DONE so EX can advance.
- busy_o = (state != IDLE).
- Flush: flush_i at any edge forces state IDLE and result_valid_o 0, discarding partial results. Flush has priority over hold_i and over acceptance.
- Special cases (RISC-V spec):
  - Divide by zero: quotient 0xFFFFFFFF; remainder = dividend (signed and unsigned).
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - With BYPASS_TRIVIAL=0 these cases iterate 32 cycles and must yield the same values.
- Operands are sampled only at acceptance; later changes to oper1_i/oper2_i are ignored.
- result_o holds its last value in IDLE; it is meaningful only when result_valid_o=1.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL* ops use a single-cycle 33x33 signed multiply. IDLE goes to DONE at the accepting edge, so the result is valid the cycle after acceptance. The MUL state is unused.
- Undefined: iterative 32-cycle multiply as above. DIV behaviour is identical in both builds.

Decomposition:
- riscv_pkg holds muldiv_op_t (3-bit enum), muldiv_state_t, and the constant MULDIV_ITERS=32.
- One sub-module, muldiv_sign_fix: combinational abs/negate of operands and results keyed by op signedness. It is shared at input and output.
- The FSM, counter and the accumulator/remainder registers live in muldiv_seq.

Test Plan:
- MUL 7 * 0xFFFFFFFD: result_o 0xFFFFFFEB; result_valid_o exactly 33 cycles after acceptance (1 with MULDIV_FAST_MUL_EN); stall_req_o high for 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. All valid one cycle after acceptance (BYPASS_TRIVIAL=1).
- flush_i pulsed on iteration 10 of a DIV: next cycle state IDLE, busy_o 0, result_valid_o never asserted. A new MUL the following cycle completes correctly.
- hold_i high for 5 cycles in DONE: result_valid_o and result_o stable throughout, no re-execution. Reset asserted mid-MUL clears all outputs asynchronously.
